posit_mul_norm_stage: RTL
=========================

Name: posit_mul_norm_stage

Overview:
Registered normalization stage directly downstream of the 7x7 unsigned fraction multiplier in the posit FMA datapath. It takes the 14-bit raw fraction product, with both hidden bits at bit 6 of their operands, plus the product's sign, scale and special flags. It normalizes the product to a hidden-one form, adjusts the scale, and extracts guard/sticky bits for the rounding stage. A 2-entry skid buffer with valid/ready handshake isolates the combinational multiplier path from downstream backpressure.

Parameters:
PROD_W, 14, raw product width from the multiplier (2 x 7-bit operands).
FRAC_W, 6, output fraction width, hidden bit excluded.
SCALE_W, 6, signed two's-complement scale width.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream product valid
in_ready  output  1  stage can accept; registered
in_prod  input  PROD_W  raw unsigned fraction product
in_scale  input  SCALE_W  signed sum of operand scales
in_sign  input  1  product sign (XOR of operand signs)
in_zero  input  1  product is zero
in_nar  input  1  product is NaR
out_valid  output  1  normalized result valid
out_ready  input  1  downstream accepts
out_frac  output  FRAC_W  normalized fraction below hidden one
out_scale  output  SCALE_W  adjusted scale
out_sign  output  1  sign passthrough
out_guard  output  1  first bit below out_frac
out_sticky  output  1  OR of all bits below guard
out_zero  output  1  zero flag
out_nar  output  1  NaR flag
out_scale_sat  output  1  scale increment saturated

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0: out_valid=0, all out_* data=0, skid entry empty, in_ready=1; in_valid is ignored.
- in_ready = NOT skid_full, driven from a register. Transfer occurs when valid&&ready on the same edge. The stage never drops or duplicates a beat.
- Latency: 1 cycle from input accept to out_valid with an empty pipeline. Throughput: 1 beat/cycle while out_ready=1.
- Skid: if the output register is occupied, out_ready=0 and an input is accepted, the beat goes to the skid entry and in_ready drops next cycle. When the output drains, skid moves to the output and in_ready returns to 1 the cycle after.
- Output data stays stable while out_valid=1 and out_ready=0.
- Normalization (p = in_prod, product lies in [2^12, 2^14)):
  - p[13]=1: frac = p[12:7], guard = p[6], sticky = |p[5:0], scale = in_scale+1.
  - p[13]=0: frac = p[11:6], guard = p[5], sticky = |p[4:0], scale = in_scale.
- Scale increment overflow (in_scale = max positive): out_scale holds the max, out_scale_sat=1. Otherwise out_scale_sat=0.
- in_nar=1 takes priority over in_zero. Either flag forces frac, guard, sticky, scale and sat to 0; sign passes through.
- p[13:12]==0 with no special flag set is illegal. The stage forces out_zero=1 with all data zeroed.
- Reset mid-operation empties both entries immediately. There is no output pulse on reset release.

Optional Feature:
POSIT_NORM_STICKY_EN.
- Defined: out_sticky is computed as above.
- Undefined: out_sticky is tied to 0, the sticky OR logic is removed, and rounding downstream degrades to guard-only round-to-nearest-up.
- Guard is computed in both builds.

Decomposition:
- Shared package (posit_pkg): PROD_W/FRAC_W/SCALE_W defaults, typedef norm_payload_t {sign, zero, nar, scale_sat, scale, frac, guard, sticky}, and constant SCALE_MAX.
- One sub-module, posit_skid_buf: a generic 2-entry valid/ready skid buffer parameterized on payload width. The normalizer is combinational logic feeding it.

Test Plan:
- in_prod=14'h1000, in_scale=0, no flags -> out_frac=6'h00, guard=0, sticky=0, out_scale=0, out_valid 1 cycle after accept.
- in_prod=14'h3F01, in_scale=5 -> out_frac=6'h3E, guard=0, sticky=1 (0 without POSIT_NORM_STICKY_EN), out_scale=6.
- in_prod=14'h2000, in_scale=31 -> out_scale=31, out_scale_sat=1, out_frac=0.
- in_nar=1 and in_zero=1 with in_prod=14'h3FFF, in_sign=1 -> out_nar=1, out_zero=0, frac/scale=0, out_sign=1.
- Backpressure: stream 4 beats with out_ready=0 -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Release out_ready -> beats emerge in order with no loss or duplication.
- Assert rst_n=0 with both entries full -> out_valid=0 and in_ready=1 immediately. No stale beat appears after release.

Source files
------------

// File: rtl/posit_pkg.sv
// -----------------------------------------------------------------------------
// posit_pkg
// Shared widths, the normalized payload record and the scale ceiling for the
// posit FMA multiply-normalize stage.
//   PROD_W    : raw fraction product width (two 7-bit operands, hidden bit at 6)
//   FRAC_W    : normalized fraction width, hidden one excluded
//   SCALE_W   : signed two's-complement scale width
//   SCALE_MAX : largest positive scale; the +1 adjustment saturates here
// -----------------------------------------------------------------------------
package posit_pkg;

  localparam int PROD_W  = 14;
  localparam int FRAC_W  = 6;
  localparam int SCALE_W = 6;

  localparam logic [SCALE_W-1:0] SCALE_MAX = {1'b0, {(SCALE_W-1){1'b1}}};

  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               nar;
    logic               scale_sat;
    logic [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]  frac;
    logic               guard;
    logic               sticky;
  } norm_payload_t;

  localparam int PAYLOAD_W = $bits(norm_payload_t);

endpackage

// File: rtl/posit_mul_norm_stage_if.sv
// -----------------------------------------------------------------------------
// posit_mul_norm_stage_if
// Upstream (product from the multiplier) and downstream (normalized result to
// the rounder) valid/ready channels of the normalize stage.
//   slave  : the stage's view (consumes in_*, produces out_*)
//   master : the surrounding datapath's view
// -----------------------------------------------------------------------------
interface posit_mul_norm_stage_if;
  import posit_pkg::*;

  // upstream channel
  logic               in_valid;
  logic               in_ready;
  logic [PROD_W-1:0]  in_prod;
  logic [SCALE_W-1:0] in_scale;
  logic               in_sign;
  logic               in_zero;
  logic               in_nar;

  // downstream channel
  logic               out_valid;
  logic               out_ready;
  logic [FRAC_W-1:0]  out_frac;
  logic [SCALE_W-1:0] out_scale;
  logic               out_sign;
  logic               out_guard;
  logic               out_sticky;
  logic               out_zero;
  logic               out_nar;
  logic               out_scale_sat;

  modport slave (
    input  in_valid, in_prod, in_scale, in_sign, in_zero, in_nar, out_ready,
    output in_ready, out_valid, out_frac, out_scale, out_sign, out_guard,
           out_sticky, out_zero, out_nar, out_scale_sat
  );

  modport master (
    output in_valid, in_prod, in_scale, in_sign, in_zero, in_nar, out_ready,
    input  in_ready, out_valid, out_frac, out_scale, out_sign, out_guard,
           out_sticky, out_zero, out_nar, out_scale_sat
  );

endinterface

// File: rtl/posit_skid_buf.sv
// -----------------------------------------------------------------------------
// posit_skid_buf
// Generic 2-entry valid/ready skid buffer: an output register plus one skid
// register. in_ready comes straight from a flop so the upstream combinational
// path never sees out_ready.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i: downstream handshake, out_data_o payload
// -----------------------------------------------------------------------------
module posit_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         in_ready_q,   in_ready_d;
  logic         accept;

  assign accept = in_valid_i & in_ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot free this edge: the skid entry is older, so it goes first.
      // in_ready is low whenever the skid is full, so no accept can coincide.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/posit_mul_norm_stage.sv
// -----------------------------------------------------------------------------
// posit_mul_norm_stage
// Normalizes the 14-bit raw fraction product to hidden-one form, adjusts the
// scale (saturating at SCALE_MAX), extracts guard/sticky, and registers the
// result through a 2-entry skid buffer.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : posit_mul_norm_stage_if.slave (in_* product channel, out_* result)
// Build option: define POSIT_NORM_STICKY_EN to compute out_sticky; otherwise
// out_sticky is constant 0 and the sticky OR trees are not built.
// -----------------------------------------------------------------------------
module posit_mul_norm_stage
  import posit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  posit_mul_norm_stage_if.slave bus
);

  // The product of two [1,2) significands lies in [1,4): bit 13 set means the
  // product reached [2,4) and needs a one-place shift plus a scale increment.
  localparam int HI_BIT = PROD_W - 1;
  localparam int LO_BIT = PROD_W - 2;

  logic sticky_hi, sticky_lo;

`ifdef POSIT_NORM_STICKY_EN
  assign sticky_hi = |bus.in_prod[HI_BIT-FRAC_W-2:0];
  assign sticky_lo = |bus.in_prod[LO_BIT-FRAC_W-2:0];
`else
  assign sticky_hi = 1'b0;
  assign sticky_lo = 1'b0;
  // Bits only the sticky OR would consume; kept as a named sink.
  logic unused_sticky_bits;
  assign unused_sticky_bits = ^bus.in_prod[LO_BIT-FRAC_W-2:0];
`endif

  norm_payload_t norm_payload;
  norm_payload_t out_payload;
  logic [PAYLOAD_W-1:0] out_bits;

  always_comb begin
    norm_payload = '0;
    if (bus.in_nar) begin
      norm_payload.nar  = 1'b1;
      norm_payload.sign = bus.in_sign;
    end else if (bus.in_zero) begin
      norm_payload.zero = 1'b1;
      norm_payload.sign = bus.in_sign;
    end else if (bus.in_prod[HI_BIT:LO_BIT] == 2'b00) begin
      // Unreachable from a legal multiplier; collapse to a clean zero.
      norm_payload.zero = 1'b1;
    end else if (bus.in_prod[HI_BIT]) begin
      norm_payload.sign   = bus.in_sign;
      norm_payload.frac   = bus.in_prod[HI_BIT-1 -: FRAC_W];
      norm_payload.guard  = bus.in_prod[HI_BIT-1-FRAC_W];
      norm_payload.sticky = sticky_hi;
      if (bus.in_scale == SCALE_MAX) begin
        norm_payload.scale     = SCALE_MAX;
        norm_payload.scale_sat = 1'b1;
      end else begin
        norm_payload.scale = bus.in_scale + SCALE_W'(1);
      end
    end else begin
      norm_payload.sign   = bus.in_sign;
      norm_payload.frac   = bus.in_prod[LO_BIT-1 -: FRAC_W];
      norm_payload.guard  = bus.in_prod[LO_BIT-1-FRAC_W];
      norm_payload.sticky = sticky_lo;
      norm_payload.scale  = bus.in_scale;
    end
  end

  posit_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (norm_payload),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_bits)
  );

  assign out_payload       = norm_payload_t'(out_bits);
  assign bus.out_frac      = out_payload.frac;
  assign bus.out_scale     = out_payload.scale;
  assign bus.out_sign      = out_payload.sign;
  assign bus.out_guard     = out_payload.guard;
  assign bus.out_sticky    = out_payload.sticky;
  assign bus.out_zero      = out_payload.zero;
  assign bus.out_nar       = out_payload.nar;
  assign bus.out_scale_sat = out_payload.scale_sat;

endmodule
